load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - Memory-stage front end feeding the word-addressed memory interface.
// - Takes one RV32I load/store per handshake.
// - Converts byte addresses to word indices.
// - Performs read-modify-write for SB/SH, since the interface writes whole words only.
// - Sign/zero-extends load results and returns them with a single-cycle response strobe.
// PARAMETERS
// - ADDR_WIDTH  32  byte-address width of req_address and mem_address
// PORTS
// clk             in   1   core clock
// reset           in   1   asynchronous, active-high reset
// req_valid       in   1   request present
// req_ready       out  1   unit idle, request accepted when req_valid & req_ready
// req_write       in   1   1 = store, 0 = load
// req_funct3      in   3   RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
// req_address     in   32  byte address
// req_store_data  in   32  store data, right-aligned
// rsp_valid       out  1   one-cycle response strobe
// rsp_load_data   out  32  extended load result (0 for stores/errors)
// rsp_error       out  1   valid with rsp_valid: illegal funct3 or misaligned
// mem_address     out  32  word index = req_address >> 2
// mem_write_data  out  32  full word to write
// mem_write_enable out 1   write strobe; memory commits on its falling edge
// mem_read_enable out  1   read strobe; memory captures on its rising edge
// mem_read_data   in   32  word read, valid the cycle after mem_read_enable rises
// BEHAVIOUR
// - Clock: single domain, clk.
// - Reset: asynchronous, active-high `reset`.
// - Reset values:
//   - state = IDLE, req_ready = 1.
//   - All other outputs = 0.
//   - Captured request registers = 0.
// - FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_COMMIT, RESP.
// - req_ready is 1 only in IDLE. The accept cycle latches address, funct3, write and data.
// - LW/LH/LB/LHU/LBU: IDLE -> RD_ISSUE (read_enable=1) -> RD_WAIT (read_enable=0,
//   capture word) -> RESP. rsp_valid is high 3 cycles after accept.
// - SW: IDLE -> WR_ISSUE (write_enable=1, write_data=store) -> WR_COMMIT (write_enable=0)
//   -> RESP. rsp_valid is high 3 cycles after accept.
// - SB/SH: IDLE -> RD_ISSUE -> RD_WAIT -> WR_ISSUE -> WR_COMMIT -> RESP. rsp_valid is high
//   5 cycles after accept.
//   - Merge: replace byte addr[1:0], or halfword addr[1], of the read word; keep other lanes.
// - Load extract:
//   - Byte lane = addr[1:0]; halfword lane = addr[1].
//   - B/H sign-extend from bit 7/15; BU/HU zero-extend.
// - Strobe timing:
//   - mem_read_enable and mem_write_enable are each high exactly one cycle per access.
//   - Each strobe is low at least one cycle between accesses.
//   - mem_address and mem_write_data are held stable from issue through commit.
// - RESP lasts one cycle:
//   - rsp_valid = 1, then -> IDLE.
//   - A new request can be accepted on the cycle after RESP.
// - Illegal funct3 (011, 110, 111; stores with funct3 >= 011):
//   - IDLE -> RESP with rsp_error = 1 and no memory strobes. Latency 1.
// - Address wrap: req_address >> 2 is passed unchanged. No range checking.
// - Reset mid-operation:
//   - FSM returns to IDLE immediately; no response is issued.
//   - If reset lands in WR_ISSUE, the memory may or may not commit the held word.
// CONFIGURATION
// - Macro LSU_MISALIGN_TRAP_EN:
//   - Defined: H/HU with addr[0] != 0, or W with addr[1:0] != 0, goes IDLE -> RESP with
//     rsp_error = 1 and no memory access.
//   - Undefined: offending low address bits are forced to 0 (aligned down); access proceeds
//     normally with rsp_error = 0.
// TESTING
// Bench preload: memory word 3 = 0x8877_6655.
// 1. LB addr 0x0F -> rsp_load_data 0xFFFF_FF88 at accept+3.
//    LBU addr 0x0F -> 0x0000_0088.
//    LH addr 0x0E -> 0xFFFF_8877.
// 2. SB data 0x0000_00AB addr 0x0D -> exactly one read and one write of word 3;
//    word 3 = 0x8877_AB55; rsp_valid at accept+5.
// 3. SW 0xDEAD_BEEF addr 0x0C, then LW addr 0x0C -> load returns 0xDEAD_BEEF.
//    Check the strobe gaps between the two accesses.
// 4. LH addr 0x0D:
//    - With LSU_MISALIGN_TRAP_EN: rsp_error = 1 at accept+1, no strobes.
//    - Without it: rsp_load_data = 0x0000_6655.
// 5. funct3 = 011 load -> rsp_error = 1, rsp_load_data = 0, req_ready back to 1 the
//    cycle after RESP.
// 6. Assert reset in WR_ISSUE of an SH -> all outputs 0 and req_ready = 1 immediately;
//    no rsp_valid; next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//
// Memory-stage front end for RV32I loads and stores. Accepts one request per
// valid/ready handshake, converts the byte address to a word index and drives
// a word-wide memory interface. Sub-word stores are done as read-modify-write
// because the memory only writes whole words. Load results are extracted from
// the addressed lane, sign/zero-extended and returned with a one-cycle
// response strobe.
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned H/HU/W (and SH/SW) accesses respond with rsp_error
//               and make no memory access.
//   undefined : offending low address bits are cleared (aligned down) and the
//               access proceeds normally.
//
// Ports
//   clk              in   core clock
//   reset            in   asynchronous, active-high reset
//   req_valid        in   request present
//   req_ready        out  unit idle; request accepted on req_valid & req_ready
//   req_write        in   1 = store, 0 = load
//   req_funct3       in   RV32I size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_address      in   byte address
//   req_store_data   in   store data, right-aligned
//   rsp_valid        out  one-cycle response strobe
//   rsp_load_data    out  extended load result (0 for stores and errors)
//   rsp_error        out  illegal funct3 or trapped misalignment
//   mem_address      out  word index (req_address >> 2)
//   mem_write_data   out  full word to write
//   mem_write_enable out  write strobe, memory commits on its falling edge
//   mem_read_enable  out  read strobe, memory captures on its rising edge
//   mem_read_data    in   read word, valid the cycle after mem_read_enable rises
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [31:0]           req_store_data,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_load_data,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_COMMIT,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t                state_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [31:0]           rsp_load_data_q;
    logic                  rsp_error_q;
    logic [ADDR_WIDTH-1:0] mem_address_q;
    logic [31:0]           mem_write_data_q;
    logic                  mem_write_enable_q;
    logic                  mem_read_enable_q;

    // Captured request; the word part of the address lives in mem_address_q
    // and the store data in mem_write_data_q, so only the lane offset is kept.
    logic                  write_q;
    logic [2:0]            funct3_q;
    logic [1:0]            offset_q;

    logic                  req_error_d;
    logic [1:0]            req_offset_d;
    logic [31:0]           load_data_d;
    logic [31:0]           merge_data_d;

    // ------------------------------------------------------------------------
    // Request decode: legality, lane offset and (optionally) misalignment.
    // ------------------------------------------------------------------------
    always_comb begin
        logic legal;
        logic is_half;
        logic is_word;

        legal   = (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                  && !(req_write && req_funct3[2]);
        is_half = (req_funct3[1:0] == 2'b01);
        is_word = (req_funct3[1:0] == 2'b10);

        // Clearing the sub-size address bits gives the aligned-down lane.
        req_offset_d = req_address[1:0];
        if (is_word) begin
            req_offset_d = 2'b00;
        end else if (is_half) begin
            req_offset_d[0] = 1'b0;
        end

`ifdef LSU_MISALIGN_TRAP_EN
        req_error_d = !legal
                      || (is_half && req_address[0])
                      || (is_word && (req_address[1:0] != 2'b00));
`else
        req_error_d = !legal;
`endif
    end

    // ------------------------------------------------------------------------
    // Load lane extraction and sub-word store merge, both from the read word.
    // ------------------------------------------------------------------------
    always_comb begin
        logic [7:0]  byte_lane;
        logic [15:0] half_lane;

        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        byte_lane    = mem_read_data[7:0];
        half_lane    = offset_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        load_data_d  = mem_read_data;
        merge_data_d = mem_read_data;

        case (offset_q)
            2'd1:    byte_lane = mem_read_data[15:8];
            2'd2:    byte_lane = mem_read_data[23:16];
            2'd3:    byte_lane = mem_read_data[31:24];
            default: byte_lane = mem_read_data[7:0];
        endcase

        case (funct3_q[1:0])
            2'b00:   load_data_d = funct3_q[2] ? {24'h0, byte_lane}
                                               : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_data_d = funct3_q[2] ? {16'h0, half_lane}
                                               : {{16{half_lane[15]}}, half_lane};
            default: load_data_d = mem_read_data;
        endcase

        // Only SB/SH reach the merge; the new lane comes from the right-aligned
        // store data held in mem_write_data_q since the accept cycle.
        if (funct3_q[0]) begin
            if (offset_q[1]) begin
                merge_data_d[31:16] = mem_write_data_q[15:0];
            end else begin
                merge_data_d[15:0]  = mem_write_data_q[15:0];
            end
        end else begin
            case (offset_q)
                2'd1:    merge_data_d[15:8]  = mem_write_data_q[7:0];
                2'd2:    merge_data_d[23:16] = mem_write_data_q[7:0];
                2'd3:    merge_data_d[31:24] = mem_write_data_q[7:0];
                default: merge_data_d[7:0]   = mem_write_data_q[7:0];
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs. Strobes and response fields default
    // low every cycle so each is high only for the single state that sets it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: every register, including captured request fields, is
            // reset so an aborted operation leaves no stale state behind.
            state_q            <= IDLE;
            req_ready_q        <= 1'b1;
            rsp_valid_q        <= 1'b0;
            rsp_load_data_q    <= '0;
            rsp_error_q        <= 1'b0;
            mem_address_q      <= '0;
            mem_write_data_q   <= '0;
            mem_write_enable_q <= 1'b0;
            mem_read_enable_q  <= 1'b0;
            write_q            <= 1'b0;
            funct3_q           <= '0;
            offset_q           <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // updates from the pre-edge values regardless of statement order.
            rsp_valid_q        <= 1'b0;
            rsp_error_q        <= 1'b0;
            rsp_load_data_q    <= '0;
            mem_write_enable_q <= 1'b0;
            mem_read_enable_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_q   <= 1'b0;
                        write_q       <= req_write;
                        funct3_q      <= req_funct3;
                        offset_q      <= req_offset_d;
                        mem_address_q <= {2'b00, req_address[ADDR_WIDTH-1:2]};
                        if (req_write) begin
                            mem_write_data_q <= req_store_data;
                        end

                        if (req_error_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                        end else if (req_write && (req_funct3[1:0] == 2'b10)) begin
                            state_q            <= WR_ISSUE;
                            mem_write_enable_q <= 1'b1;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state_q           <= RD_ISSUE;
                            mem_read_enable_q <= 1'b1;
                        end
                    end
                end

                RD_ISSUE: state_q <= RD_WAIT;

                RD_WAIT: begin
                    if (write_q) begin
                        state_q            <= WR_ISSUE;
                        mem_write_data_q   <= merge_data_d;
                        mem_write_enable_q <= 1'b1;
                    end else begin
                        state_q         <= RESP;
                        rsp_valid_q     <= 1'b1;
                        rsp_load_data_q <= load_data_d;
                    end
                end

                WR_ISSUE: state_q <= WR_COMMIT;

                WR_COMMIT: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end

                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end

                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready        = req_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_load_data    = rsp_load_data_q;
    assign rsp_error        = rsp_error_q;
    assign mem_address      = mem_address_q;
    assign mem_write_data   = mem_write_data_q;
    assign mem_write_enable = mem_write_enable_q;
    assign mem_read_enable  = mem_read_enable_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for load_store_unit. A small behavioural word
// memory answers the strobes: it captures read data on the rising edge of
// mem_read_enable and commits writes on the falling edge of mem_write_enable.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_address = 32'h0;
    logic [31:0] req_store_data = 32'h0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_load_data;
    logic        rsp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [31:0] mem_read_data = 32'h0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_address      (req_address),
        .req_store_data   (req_store_data),
        .rsp_valid        (rsp_valid),
        .rsp_load_data    (rsp_load_data),
        .rsp_error        (rsp_error),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_read_data    (mem_read_data)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [0:15];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_rd_addr = 32'h0;
    logic [31:0] last_wr_addr = 32'h0;

    always @(posedge mem_read_enable) begin
        mem_read_data <= mem[mem_address[3:0]];
        last_rd_addr  = mem_address;
        rd_cnt++;
    end

    always @(negedge mem_write_enable) begin
        if (!reset) begin
            mem[mem_address[3:0]] <= mem_write_data;
            last_wr_addr = mem_address;
            wr_cnt++;
        end
    end

    // Each strobe must be a single-cycle pulse, which also guarantees at
    // least one low cycle between consecutive accesses.
    int   strobe_viol = 0;
    logic prev_re = 1'b0;
    logic prev_we = 1'b0;
    always @(negedge clk) begin
        if (mem_read_enable === 1'b1 && prev_re) strobe_viol++;
        if (mem_write_enable === 1'b1 && prev_we) strobe_viol++;
        prev_re = (mem_read_enable === 1'b1);
        prev_we = (mem_write_enable === 1'b1);
    end

    // ---------------- transaction driver ----------------
    // lat counts clock edges from the accept edge (edge 1 = accept edge)
    // up to the edge after which rsp_valid is seen; -1 on timeout.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic [31:0] data,
                          output logic err, output int n_rd, output int n_wr,
                          output logic ready_after);
        int rd0;
        int wr0;
        int guard;
        req_valid      = 1'b1;
        req_write      = w;
        req_funct3     = f3;
        req_address    = a;
        req_store_data = d;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk); #1;
        req_valid      = 1'b0;
        req_write      = 1'b0;
        req_funct3     = 3'b000;
        req_address    = 32'h0;
        req_store_data = 32'h0;
        lat  = -1;
        data = 32'h0;
        err  = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (rsp_valid) begin
                lat  = n;
                data = rsp_load_data;
                err  = rsp_error;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ready_after = req_ready && !rsp_valid;
        n_rd = rd_cnt - rd0;
        n_wr = wr_cnt - wr0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if ({rsp_valid, rsp_error, mem_read_enable, mem_write_enable} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b want 0000", {rsp_valid, rsp_error, mem_read_enable, mem_write_enable}); end
        checks++; if ({rsp_load_data, mem_address, mem_write_data} !== 96'h0) begin
            errors++; $display("FAIL reset_data: got %h/%h/%h want 0", rsp_load_data, mem_address, mem_write_data); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_extract();
        int lat; logic [31:0] data; logic err; int nr; int nw; logic rdy;
        do_req(1'b0, 3'b000, 32'h0F, 32'h0, lat, data, err, nr, nw, rdy);
        checks++; if (data !== 32'hFFFF_FF88) begin errors++; $display("FAIL lb_0f: got %h want ffffff88", data); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d want 3", lat); end
        checks++; if ({err, nr[3:0], nw[3:0]} !== 9'b0_0001_0000) begin
            errors++; $display("FAIL lb_access: err=%b rd=%0d wr=%0d want 0/1/0", err, nr, nw); end
        checks++; if (last_rd_addr !== 32'h3) begin errors++; $display("FAIL lb_word_index: got %h want 3", last_rd_addr); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL lb_ready_after: got %b want 1", rdy); end

        do_req(1'b0, 3'b100, 32'h0F, 32'h0, lat, data, err, nr, nw, rdy);
        checks++; if (data !== 32'h0000_0088) begin errors++; $display("FAIL lbu_0f: got %h want 00000088", data); end
        do_req(1'b0, 3'b001, 32'h0E, 32'h0, lat, data, err, nr, nw, rdy);
        checks++; if (data !== 32'hFFFF_8877) begin errors++; $display("FAIL lh_0e: got %h want ffff8877", data); end
        do_req(1'b0, 3'b101, 32'h0E, 32'h0, lat, data, err, nr, nw, rdy);
        checks++; if (data !== 32'h0000_8877) begin errors++; $display("FAIL lhu_0e: got %h want 00008877", data); end
        do_req(1'b0, 3'b000, 32'h0D, 32'h0, lat, data, err, nr, nw, rdy);
        checks++; if (data !== 32'h0000_0066) begin errors++; $display("FAIL lb_0d: got %h want 00000066", data); end
        do_req(1'b0, 3'b010, 32'h0C, 32'h0, lat, data, err, nr, nw, rdy);
        checks++; if (data !== 32'h8877_6655) begin errors++; $display("FAIL lw_0c: got %h want 88776655", data); end
    endtask

    task automatic test_store_merge();
        int lat; logic [31:0] data; logic err; int nr; int nw; logic rdy;
        do_req(1'b1, 3'b000, 32'h0D, 32'h0000_00AB, lat, data, err, nr, nw, rdy);
        checks++; if (mem[3] !== 32'h8877_AB55) begin errors++; $display("FAIL sb_word: got %h want 8877ab55", mem[3]); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL sb_latency: got %0d want 5", lat); end
        checks++; if ({nr[3:0], nw[3:0]} !== 8'h11) begin errors++; $display("FAIL sb_access: rd=%0d wr=%0d want 1/1", nr, nw); end
        checks++; if (last_wr_addr !== 32'h3) begin errors++; $display("FAIL sb_word_index: got %h want 3", last_wr_addr); end
        checks++; if ({err, data} !== 33'h0) begin errors++; $display("FAIL sb_rsp: err=%b data=%h want 0/0", err, data); end

        do_req(1'b1, 3'b001, 32'h0E, 32'hFFFF_1234, lat, data, err, nr, nw, rdy);
        checks++; if (mem[3] !== 32'h1234_AB55) begin errors++; $display("FAIL sh_word: got %h want 1234ab55", mem[3]); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL sh_latency: got %0d want 5", lat); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] data; logic err; int nr; int nw; logic rdy;
        do_req(1'b1, 3'b010, 32'h0C, 32'hDEAD_BEEF, lat, data, err, nr, nw, rdy);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d want 3", lat); end
        checks++; if ({nr[3:0], nw[3:0]} !== 8'h01) begin errors++; $display("FAIL sw_access: rd=%0d wr=%0d want 0/1", nr, nw); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sw_ready_after: got %b want 1", rdy); end
        do_req(1'b0, 3'b010, 32'h0C, 32'h0, lat, data, err, nr, nw, rdy);
        checks++; if (data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_lw_data: got %h want deadbeef", data); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency: got %0d want 3", lat); end
        checks++; if (strobe_viol !== 0) begin errors++; $display("FAIL strobe_gap: got %0d wide pulses want 0", strobe_viol); end
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] data; logic err; int nr; int nw; logic rdy;
        do_req(1'b1, 3'b010, 32'h0C, 32'h8877_6655, lat, data, err, nr, nw, rdy);
        checks++; if (mem[3] !== 32'h8877_6655) begin errors++; $display("FAIL restore_word: got %h want 88776655", mem[3]); end
        do_req(1'b0, 3'b001, 32'h0D, 32'h0, lat, data, err, nr, nw, rdy);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if ({err, data} !== 33'h1_0000_0000) begin errors++; $display("FAIL lh_0d_trap: err=%b data=%h want 1/0", err, data); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL lh_0d_latency: got %0d want 1", lat); end
        checks++; if ({nr[3:0], nw[3:0]} !== 8'h00) begin errors++; $display("FAIL lh_0d_access: rd=%0d wr=%0d want 0/0", nr, nw); end
        do_req(1'b0, 3'b010, 32'h0E, 32'h0, lat, data, err, nr, nw, rdy);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL lw_0e_trap: got %b want 1", err); end
`else
        checks++; if ({err, data} !== 33'h0_0000_6655) begin errors++; $display("FAIL lh_0d_align: err=%b data=%h want 0/00006655", err, data); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL lh_0d_latency: got %0d want 3", lat); end
        do_req(1'b0, 3'b010, 32'h0E, 32'h0, lat, data, err, nr, nw, rdy);
        checks++; if ({err, data} !== 33'h0_8877_6655) begin errors++; $display("FAIL lw_0e_align: err=%b data=%h want 0/88776655", err, data); end
`endif
    endtask

    task automatic test_illegal();
        int lat; logic [31:0] data; logic err; int nr; int nw; logic rdy;
        do_req(1'b0, 3'b011, 32'h0C, 32'h0, lat, data, err, nr, nw, rdy);
        checks++; if ({err, data} !== 33'h1_0000_0000) begin errors++; $display("FAIL ill_load: err=%b data=%h want 1/0", err, data); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL ill_latency: got %0d want 1", lat); end
        checks++; if ({nr[3:0], nw[3:0]} !== 8'h00) begin errors++; $display("FAIL ill_access: rd=%0d wr=%0d want 0/0", nr, nw); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL ill_ready_after: got %b want 1", rdy); end
        do_req(1'b0, 3'b110, 32'h0C, 32'h0, lat, data, err, nr, nw, rdy);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_load_110: got %b want 1", err); end
        do_req(1'b1, 3'b100, 32'h0C, 32'h1, lat, data, err, nr, nw, rdy);
        checks++; if ({err, nr[3:0], nw[3:0]} !== 9'b1_0000_0000) begin
            errors++; $display("FAIL ill_store_100: err=%b rd=%0d wr=%0d want 1/0/0", err, nr, nw); end
        checks++; if (mem[3] !== 32'h8877_6655) begin errors++; $display("FAIL ill_store_mem: got %h want 88776655", mem[3]); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] data; logic err; int nr; int nw; logic rdy;
        int guard;
        logic saw_rsp;
        req_valid      = 1'b1;
        req_write      = 1'b1;
        req_funct3     = 3'b001;
        req_address    = 32'h16;
        req_store_data = 32'h0000_5A5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        guard = 0;
        while (!mem_write_enable && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++; if (guard !== 2) begin errors++; $display("FAIL rst_mid_reach_wr: got %0d cycles want 2", guard); end
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
        checks++; if ({rsp_valid, rsp_error, mem_read_enable, mem_write_enable, rsp_load_data, mem_address, mem_write_data} !== 100'h0) begin
            errors++; $display("FAIL rst_mid_outputs: v=%b e=%b re=%b we=%b d=%h a=%h wd=%h want all 0",
                               rsp_valid, rsp_error, mem_read_enable, mem_write_enable, rsp_load_data, mem_address, mem_write_data); end
        saw_rsp = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            saw_rsp = saw_rsp | rsp_valid;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            saw_rsp = saw_rsp | rsp_valid;
        end
        checks++; if (saw_rsp !== 1'b0) begin errors++; $display("FAIL rst_mid_no_rsp: got %b want 0", saw_rsp); end
        do_req(1'b0, 3'b010, 32'h0C, 32'h0, lat, data, err, nr, nw, rdy);
        checks++; if ({err, data} !== 33'h0_8877_6655) begin errors++; $display("FAIL rst_mid_lw: err=%b data=%h want 0/88776655", err, data); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL rst_mid_lw_latency: got %0d want 3", lat); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[3] = 32'h8877_6655;
        test_reset();
        test_load_extract();
        test_store_merge();
        test_back_to_back();
        test_misalign();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
